pc_fetch: RTL and testbench

Program-counter register and instruction-fetch stage of the miniRV core. It holds the architectural PC and issues one request per instruction to the instruction ROM over a req/ack handshake. It presents the fetched word to decode with a valid/ready handshake. When decode accepts, it loads the next PC computed by the downstream next-PC logic from the current `pc`.

---
 rtl/pc_fetch.sv | 103 ++++++++++
 tb/tb_pc_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Program counter register and instruction-fetch stage of the miniRV core.
// Fetches one word per instruction from IROM and hands it to decode with valid/ready.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] fetch_cnt,
    output logic        pc_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        pc_misalign_q, pc_misalign_d;
    logic        irom_req_q, irom_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic        accept;

    assign accept = (state_q == S_VALID) && inst_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        fetch_cnt_d   = fetch_cnt_q;
        pc_misalign_d = pc_misalign_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (irom_ack) begin
                    inst_d  = irom_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (accept) begin
                    // A misaligned npc is still committed so debug can see where it went.
                    pc_d        = npc;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    if (npc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        state_d       = S_ERR;
                        pc_misalign_d = 1'b1;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        irom_req_d   = (state_d == S_REQ);
        inst_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            fetch_cnt_q   <= '0;
            pc_misalign_q <= 1'b0;
            irom_req_q    <= 1'b0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            fetch_cnt_q   <= fetch_cnt_d;
            pc_misalign_q <= pc_misalign_d;
            irom_req_q    <= irom_req_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    assign pc          = pc_q;
    assign irom_addr   = pc_q;
    assign inst        = inst_q;
    assign fetch_cnt   = fetch_cnt_q;
    assign pc_misalign = pc_misalign_q;
    assign irom_req    = irom_req_q;
    assign inst_valid  = inst_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, counter wrap,
// and randomized traffic against a transaction-level reference model.
module tb_pc_fetch;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack;
    logic [31:0] irom_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] fetch_cnt;
    logic        pc_misalign;

    int unsigned checks;
    int unsigned errors;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .npc        (npc),
        .pc         (pc),
        .irom_req   (irom_req),
        .irom_addr  (irom_addr),
        .irom_ack   (irom_ack),
        .irom_rdata (irom_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_cnt  (fetch_cnt),
        .pc_misalign(pc_misalign)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] npc;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic ready, input logic [31:0] n,
                       input logic e_req, input logic e_valid, input logic [31:0] e_pc,
                       input logic [31:0] e_inst, input logic [31:0] e_cnt, input logic e_mis);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready; v.npc = n;
        v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_cnt = e_cnt; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic ready, input logic [31:0] n);
        @(negedge cpu_clk);
        cpu_rst = rst; irom_ack = ack; irom_rdata = rdata; inst_ready = ready; npc = n;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic e_valid,
                           input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_cnt, input logic e_mis);
        chk({tag, ".irom_req"},    {31'd0, irom_req},    {31'd0, e_req});
        chk({tag, ".inst_valid"},  {31'd0, inst_valid},  {31'd0, e_valid});
        chk({tag, ".pc"},          pc,                   e_pc);
        chk({tag, ".irom_addr"},   irom_addr,            e_pc);
        chk({tag, ".inst"},        inst,                 e_inst);
        chk({tag, ".fetch_cnt"},   fetch_cnt,            e_cnt);
        chk({tag, ".pc_misalign"}, {31'd0, pc_misalign}, {31'd0, e_mis});
    endtask

    // Reference model: fetch phases named by intent, advanced once per clock.
    localparam int P_IDLE = 0, P_FETCH = 1, P_PRESENT = 2, P_DEAD = 3;
    int          m_phase;
    logic [31:0] m_pc, m_inst, m_cnt;
    logic        m_mis;

    task automatic model_step(input logic rst, input logic ack, input logic [31:0] rdata,
                              input logic ready, input logic [31:0] n);
        if (rst) begin
            m_phase = P_IDLE; m_pc = 32'h0; m_inst = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
        end else if (m_phase == P_IDLE) begin
            m_phase = P_FETCH;
        end else if (m_phase == P_FETCH) begin
            if (ack) begin
                m_inst = rdata;
                m_phase = P_PRESENT;
            end
        end else if (m_phase == P_PRESENT) begin
            if (ready) begin
                m_pc = n;
                m_cnt = m_cnt + 1;
                if (n % 4 == 0) m_phase = P_FETCH;
                else begin
                    m_phase = P_DEAD;
                    m_mis = 1'b1;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cpu_rst = 1'b1; irom_ack = 1'b0; irom_rdata = '0; inst_ready = 1'b0; npc = '0;

        //   rst ack rdata         rdy npc            req val pc             inst           cnt mis
        add(1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 32'hA000_0000, 0, 32'h0,         0, 1, 32'h0,         32'hA000_0000, 0, 0);
        add(0, 0, 32'h0,         1, 32'h4,         1, 0, 32'h4,         32'hA000_0000, 1, 0);
        add(0, 1, 32'hA000_0001, 0, 32'h0,         0, 1, 32'h4,         32'hA000_0001, 1, 0);
        add(0, 0, 32'h0,         1, 32'h8,         1, 0, 32'h8,         32'hA000_0001, 2, 0);
        add(0, 1, 32'hA000_0002, 0, 32'h0,         0, 1, 32'h8,         32'hA000_0002, 2, 0);
        add(0, 0, 32'h0,         1, 32'hC,         1, 0, 32'hC,         32'hA000_0002, 3, 0);
        // ROM wait states; ready during fetch must be ignored
        add(0, 0, 32'h1111_1111, 1, 32'h50,        1, 0, 32'hC,         32'hA000_0002, 3, 0);
        add(0, 0, 32'h2222_2222, 1, 32'h54,        1, 0, 32'hC,         32'hA000_0002, 3, 0);
        add(0, 1, 32'hB000_0003, 1, 32'h58,        0, 1, 32'hC,         32'hB000_0003, 3, 0);
        // decode stall with npc toggling; stray ack ignored
        add(0, 1, 32'hFFFF_FFFF, 0, 32'h40,        0, 1, 32'hC,         32'hB000_0003, 3, 0);
        add(0, 0, 32'h0,         0, 32'h80,        0, 1, 32'hC,         32'hB000_0003, 3, 0);
        add(0, 0, 32'h0,         0, 32'h44,        0, 1, 32'hC,         32'hB000_0003, 3, 0);
        add(0, 0, 32'h0,         1, 32'h10,        1, 0, 32'h10,        32'hB000_0003, 4, 0);
        add(0, 1, 32'hC000_0004, 0, 32'h0,         0, 1, 32'h10,        32'hC000_0004, 4, 0);
        // misaligned jump, then frozen
        add(0, 0, 32'h0,         1, 32'h0000_0102, 0, 0, 32'h0000_0102, 32'hC000_0004, 5, 1);
        add(0, 1, 32'h5555_5555, 1, 32'h0,         0, 0, 32'h0000_0102, 32'hC000_0004, 5, 1);
        add(0, 0, 32'h0,         1, 32'h20,        0, 0, 32'h0000_0102, 32'hC000_0004, 5, 1);
        add(1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         32'h0,         0, 0);
        // reset mid-fetch, ack arrives the cycle after
        add(1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 32'hDEAD_BEEF, 0, 32'h0,         1, 0, 32'h0,         32'h0,         0, 0);
        add(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 32'h0000_0011, 0, 32'h0,         0, 1, 32'h0,         32'h0000_0011, 0, 0);
        // reset beats accept
        add(1, 0, 32'h0,         1, 32'h4,         0, 0, 32'h0,         32'h0,         0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].npc);
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_valid, vecs[i].e_pc,
                    vecs[i].e_inst, vecs[i].e_cnt, vecs[i].e_mis);
        end

        // Counter wrap: preload fetch_cnt while holding an instruction, then accept.
        drive(0, 0, 32'h0, 0, 32'h0);
        drive(0, 1, 32'h7777_0000, 0, 32'h0);
        chk("wrap.valid", {31'd0, inst_valid}, 32'd1);
        @(negedge cpu_clk);
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        #1;
        chk("wrap.preload", fetch_cnt, 32'hFFFF_FFFF);
        inst_ready = 1'b1; npc = 32'h0000_0100;
        @(posedge cpu_clk);
        #1;
        chk("wrap.cnt", fetch_cnt, 32'h0);
        chk("wrap.pc", pc, 32'h0000_0100);

        // Randomized traffic against the reference model.
        drive(1, 0, 32'h0, 0, 32'h0);
        model_step(1, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 2000; i++) begin
            logic        r, a, rd;
            logic [31:0] d, n;
            r  = ($urandom_range(0, 63) == 0);
            a  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) != 0);
            d  = $urandom;
            n  = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
            if ($urandom_range(0, 40) == 0) n[1:0] = 2'($urandom_range(1, 3));
            drive(r, a, d, rd, n);
            model_step(r, a, d, rd, n);
            chk_all($sformatf("rnd%0d", i), m_phase == P_FETCH, m_phase == P_PRESENT,
                    m_pc, m_inst, m_cnt, m_mis);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
